// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin owner of the shared 2:1 mux with a bounded hold time
// and one dead cycle on every change of ownership.
//
// state | meaning
// IDLE  | no owner, mux disabled, oSel keeps its last value
// OWN_A | A owns the mux, oSel=0
// OWN_B | B owns the mux, oSel=1
// GAP   | single dead cycle between owners, mux disabled
module mux_arbiter #(
   parameter int HOLD_MAX = 4,
   parameter int CNT_W    = 3
) (
   input  logic iClk,
   input  logic iClr,
   input  logic iReqA,
   input  logic iReqB,
   output logic oGntA,
   output logic oGntB,
   output logic oSel,
   output logic oEnb,
   output logic oBusy
);

   typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, GAP} state_t;

   localparam logic [CNT_W-1:0] L_HOLD_MAX = CNT_W'(HOLD_MAX);
   localparam logic [CNT_W-1:0] L_ONE      = CNT_W'(1);

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_last_b, w_last_b_nxt;
   logic             r_gnt_a, r_gnt_b, r_sel, r_enb, r_busy;
   logic             w_pick_a, w_pick_b, w_at_max;

   // Tie goes to whoever was not served last.
   assign w_pick_a = iReqA & (~iReqB | r_last_b);
   assign w_pick_b = iReqB & (~iReqA | ~r_last_b);
   assign w_at_max = (r_cnt >= L_HOLD_MAX);

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_last_b_nxt = r_last_b;
      case (r_state)
         IDLE, GAP: begin
            if (w_pick_a) begin
               w_state_nxt  = OWN_A;
               w_cnt_nxt    = L_ONE;
               w_last_b_nxt = 1'b0;
            end else if (w_pick_b) begin
               w_state_nxt  = OWN_B;
               w_cnt_nxt    = L_ONE;
               w_last_b_nxt = 1'b1;
            end else begin
               w_state_nxt  = IDLE;
            end
         end
         OWN_A: begin
            if (!iReqA)          w_state_nxt = iReqB ? GAP : IDLE;
            else if (!w_at_max)  w_cnt_nxt   = r_cnt + L_ONE;
            else if (iReqB)      w_state_nxt = GAP;
         end
         OWN_B: begin
            if (!iReqB)          w_state_nxt = iReqA ? GAP : IDLE;
            else if (!w_at_max)  w_cnt_nxt   = r_cnt + L_ONE;
            else if (iReqA)      w_state_nxt = GAP;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with r_state.
   always_ff @(posedge iClk or negedge iClr) begin
      if (!iClr) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_last_b <= 1'b1;
         r_gnt_a  <= 1'b0;
         r_gnt_b  <= 1'b0;
         r_sel    <= 1'b0;
         r_enb    <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_last_b <= w_last_b_nxt;
         r_gnt_a  <= (w_state_nxt == OWN_A);
         r_gnt_b  <= (w_state_nxt == OWN_B);
         r_enb    <= (w_state_nxt == OWN_A) || (w_state_nxt == OWN_B);
         r_busy   <= (w_state_nxt != IDLE);
         if (w_state_nxt == OWN_B)      r_sel <= 1'b1;
         else if (w_state_nxt == OWN_A) r_sel <= 1'b0;
      end
   end

   assign oGntA = r_gnt_a;
   assign oGntB = r_gnt_b;
   assign oSel  = r_sel;
   assign oEnb  = r_enb;
   assign oBusy = r_busy;

endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: scoreboard bench for mux_arbiter; a behavioural owner model
// queues the expected {gntA,gntB,sel,enb,busy} for every driven cycle.
module tb_mux_arbiter;

   localparam int HOLD_MAX = 4;

   localparam logic [4:0] V_OWN_A = 5'b10011;
   localparam logic [4:0] V_OWN_B = 5'b01111;
   localparam logic [4:0] V_GAP_A = 5'b00001;
   localparam logic [4:0] V_GAP_B = 5'b00101;
   localparam logic [4:0] V_IDL_A = 5'b00000;
   localparam logic [4:0] V_IDL_B = 5'b00100;

   logic iClk = 1'b0;
   logic iClr = 1'b0;
   logic iReqA = 1'b1;
   logic iReqB = 1'b1;
   logic oGntA, oGntB, oSel, oEnb, oBusy;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   logic [4:0] sb_q[$];
   logic [4:0] last_obs;

   // behavioural model: owner 0=none, 1=A, 2=B; in_gap marks the dead cycle
   int   m_owner;
   bit   m_in_gap;
   int   m_held;
   bit   m_last_b;
   bit   m_sel;

   mux_arbiter #(.HOLD_MAX(HOLD_MAX), .CNT_W(3)) dut (
      .iClk  (iClk),
      .iClr  (iClr),
      .iReqA (iReqA),
      .iReqB (iReqB),
      .oGntA (oGntA),
      .oGntB (oGntB),
      .oSel  (oSel),
      .oEnb  (oEnb),
      .oBusy (oBusy)
   );

   always #5 iClk = ~iClk;

   task automatic check_eq(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      n_checks++;
      if (obs !== exp)
         $display("FAIL %s: got %b, want %b (t=%0t)", tag, obs, exp, $time);
      else
         n_pass++;
   endtask

   function automatic logic [4:0] cur_outputs();
      return {oGntA, oGntB, oSel, oEnb, oBusy};
   endfunction

   task automatic model_reset();
      m_owner  = 0;
      m_in_gap = 1'b0;
      m_held   = 0;
      m_last_b = 1'b1;
      m_sel    = 1'b0;
   endtask

   task automatic model_grant(input int who);
      m_owner  = who;
      m_in_gap = 1'b0;
      m_held   = 1;
      m_last_b = (who == 2);
      m_sel    = (who == 2);
   endtask

   task automatic model_step(input bit a, input bit b);
      bit mine, other;
      if (!iClr) begin
         model_reset();
         return;
      end
      if (m_owner == 0) begin
         if (a && b)      model_grant(m_last_b ? 1 : 2);
         else if (a)      model_grant(1);
         else if (b)      model_grant(2);
         else             m_in_gap = 1'b0;
      end else begin
         mine  = (m_owner == 1) ? a : b;
         other = (m_owner == 1) ? b : a;
         if (!mine || (m_held >= HOLD_MAX && other)) begin
            m_owner  = 0;
            m_in_gap = other;
         end else if (m_held < HOLD_MAX) begin
            m_held++;
         end
      end
   endtask

   function automatic logic [4:0] model_out();
      logic ga, gb;
      ga = (m_owner == 1);
      gb = (m_owner == 2);
      return {ga, gb, m_sel, ga | gb, (m_owner != 0) | m_in_gap};
   endfunction

   // Called at a falling edge; returns at the next falling edge.
   task automatic drive_cycle(input logic a, input logic b);
      logic [4:0] exp_v;
      iReqA = a;
      iReqB = b;
      model_step(a, b);
      sb_q.push_back(model_out());
      @(posedge iClk);
      #1;
      cyc++;
      last_obs = cur_outputs();
      exp_v = sb_q.pop_front();
      check_eq($sformatf("sb@%0d", cyc), last_obs, exp_v);
      check_eq($sformatf("mutex@%0d", cyc), {4'b0, oGntA & oGntB}, 5'b0);
      check_eq($sformatf("enb_eq@%0d", cyc), {4'b0, oGntA | oGntB}, {4'b0, oEnb});
      @(negedge iClk);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not reach its end");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [4:0] simul_tab [11];
      simul_tab = '{V_OWN_A, V_OWN_A, V_OWN_A, V_OWN_A, V_GAP_A,
                    V_OWN_B, V_OWN_B, V_OWN_B, V_OWN_B, V_GAP_B, V_OWN_A};
      model_reset();

      // reset with both requests high
      #3;
      check_eq("rst_out", cur_outputs(), 5'b00000);
      @(negedge iClk);
      drive_cycle(1'b1, 1'b1);
      drive_cycle(1'b1, 1'b1);

      // release: first grant needs an edge
      iClr  = 1'b1;
      iReqA = 1'b1;
      iReqB = 1'b0;
      #1;
      check_eq("rel_pre_edge", cur_outputs(), 5'b00000);
      drive_cycle(1'b1, 1'b0);
      check_eq("rel_gnt_a", last_obs, V_OWN_A);
      drive_cycle(1'b0, 1'b0);
      check_eq("rel_idle", last_obs, V_IDL_A);

      // B alone for 10 cycles: saturates, never gaps
      for (int i = 0; i < 10; i++) begin
         drive_cycle(1'b0, 1'b1);
         check_eq($sformatf("single_b%0d", i), last_obs, V_OWN_B);
      end
      drive_cycle(1'b1, 1'b1);
      check_eq("sat_preempt", last_obs, V_GAP_B);
      drive_cycle(1'b0, 1'b0);
      check_eq("gap_to_idle", last_obs, V_IDL_B);

      // simultaneous requests from IDLE
      for (int i = 0; i < 11; i++) begin
         drive_cycle(1'b1, 1'b1);
         check_eq($sformatf("simul%0d", i), last_obs, simul_tab[i]);
      end
      drive_cycle(1'b0, 1'b0);
      check_eq("simul_idle", last_obs, V_IDL_A);

      // early release by A while B waits
      drive_cycle(1'b1, 1'b0);
      drive_cycle(1'b1, 1'b1);
      check_eq("early_own", last_obs, V_OWN_A);
      drive_cycle(1'b0, 1'b1);
      check_eq("early_gap", last_obs, V_GAP_A);
      drive_cycle(1'b0, 1'b1);
      check_eq("early_gnt_b", last_obs, V_OWN_B);
      drive_cycle(1'b0, 1'b0);
      check_eq("early_idle", last_obs, V_IDL_B);

      // B pulses only during A's 4th cycle; A is re-granted with a fresh count
      for (int i = 0; i < 4; i++) begin
         drive_cycle(1'b1, 1'b0);
         check_eq($sformatf("fb_own%0d", i), last_obs, V_OWN_A);
      end
      drive_cycle(1'b1, 1'b1);
      check_eq("fb_gap", last_obs, V_GAP_A);
      drive_cycle(1'b1, 1'b0);
      check_eq("fb_regrant", last_obs, V_OWN_A);
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b1, 1'b1);
         check_eq($sformatf("fb_cnt%0d", i + 2), last_obs, V_OWN_A);
      end
      drive_cycle(1'b1, 1'b1);
      check_eq("fb_hold_end", last_obs, V_GAP_A);
      drive_cycle(1'b0, 1'b0);

      // async reset during OWN_B, then tie goes to A
      drive_cycle(1'b0, 1'b1);
      check_eq("mid_own_b", last_obs, V_OWN_B);
      #2;
      iClr = 1'b0;
      #1;
      check_eq("async_rst", cur_outputs(), 5'b00000);
      model_reset();
      @(negedge iClk);
      iClr = 1'b1;
      drive_cycle(1'b1, 1'b1);
      check_eq("post_rst_a", last_obs, V_OWN_A);
      drive_cycle(1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mux_arbiter.md
Name: mux_arbiter

Overview:
- Round-robin arbiter that shares the library 2:1 mux between two requesters, A and B.
- Drives the mux select and enable directly. Returns a registered grant to each requester.
- Bounds the time either requester can hold the mux, and inserts one dead cycle whenever ownership changes.
- Sits between the two requesting blocks and the mux cell, in the same clock domain.

Parameters:
- HOLD_MAX, 4, maximum consecutive granted cycles before a waiting requester preempts the owner; legal range >= 1.
- CNT_W, 3, width of the hold counter; must be >= clog2(HOLD_MAX+1).

Ports:
- iClk  input  1  clock; all state updates on the rising edge.
- iClr  input  1  asynchronous, active-low reset.
- iReqA  input  1  requester A wants the mux; held high while use continues.
- iReqB  input  1  requester B wants the mux.
- oGntA  output  1  A owns the mux this cycle.
- oGntB  output  1  B owns the mux this cycle.
- oSel  output  1  mux select; 0 = path A (iA), 1 = path B (iB).
- oEnb  output  1  mux enable; high only while some owner is granted.
- oBusy  output  1  state is not IDLE.

Behaviour:
- One clock (iClk). Reset iClr is asynchronous and active-low.
- All outputs are registered, with no combinational path from inputs to outputs.
- Reset (iClr=0, asynchronous): state=IDLE; oGntA=oGntB=oEnb=oBusy=oSel=0; hold counter=0; last-served=B, so A wins the first tie.
- States: IDLE, OWN_A, OWN_B, GAP.
- IDLE / GAP arbitration on each edge:
  - Only one request high: grant that requester.
  - Both high: grant the requester that is not last-served.
  - Neither high: go to IDLE.
- Entering OWN_x:
  - oGntx=1, oEnb=1, oSel=(x==B).
  - Counter=1; last-served=x.
- Latency: a request sampled high in IDLE gives its grant on the next edge (1 cycle).
- OWN_x, on each edge:
  - iReqx=0: release. Go to GAP if the other requester is high, else to IDLE.
  - iReqx=1, counter<HOLD_MAX: stay; counter+1.
  - iReqx=1, counter==HOLD_MAX, other request high: preempt to GAP.
  - iReqx=1, counter==HOLD_MAX, other request low: stay; counter saturates at HOLD_MAX.
    - A later request from the other side preempts on the next edge.
- GAP (exactly one cycle):
  - oGntA=oGntB=oEnb=0; oSel holds its previous value; oBusy=1.
  - Next state comes from IDLE-style arbitration using the updated last-served, so the other side wins any tie.
  - If the other side has dropped its request and the previous owner still requests, the previous owner is re-granted with counter=1.
- IDLE: oSel holds its last value; oEnb=0; oBusy=0.
- Both grants are never high together. No grant is high while oEnb=0.
- Reset mid-grant: all outputs drop asynchronously in the same cycle iClr falls. The first grant after reset release takes at least one edge.
- The counter never wraps. It is cleared only on grant entry or reset.

Test Plan:
- Reset: drive iClr=0 with requests high -> all outputs 0 immediately. Release iClr with iReqA=1 -> oGntA=1, oEnb=1, oSel=0 after the first edge.
- Single requester: iReqB held high for 10 cycles, iReqA=0 -> oGntB=1, oSel=1 continuously. The counter saturates at 4 with no GAP.
- Simultaneous requests from IDLE, HOLD_MAX=4:
  - oGntA high for exactly 4 cycles.
  - Then 1 GAP cycle with oEnb=0 and oSel=0.
  - Then oGntB high with oSel=1 for 4 cycles, then GAP, then back to A.
- Early release: A granted, iReqA drops after 2 cycles while iReqB=1 -> GAP for 1 cycle, then oGntB=1. Drop both requests -> IDLE with oBusy=0.
- GAP fallback: iReqB pulses high only during A's 4th grant cycle -> GAP, then B is low, so oGntA=1 again with counter restarted at 1.
- Reset mid-grant: pulse iClr low during OWN_B -> oGntB, oEnb and oSel go to 0 asynchronously. After release with both requests high -> A is granted first, since last-served=B.
- Throughout every scenario, check on each cycle: oGntA & oGntB == 0, and (oGntA | oGntB) == oEnb.
